// File: rtl/pipe_reg_chain_if.sv
// rtl/pipe_reg_chain_if.sv - datapath bundle between the PIPE pipeline bank and its hazard/feed logic
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       bubble;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [DEPTH-1:0]       out_valid;

  // Feed side: issue logic plus hazard unit
  modport master (
    output in_data, in_valid, stall, bubble,
    input  out_data, out_valid
  );

  // Register bank side
  modport slave (
    input  in_data, in_valid, stall, bubble,
    output out_data, out_valid
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - multi-stage pipeline register bank with stall/bubble control, error flags and perf counters
module pipe_reg_chain #(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 3,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             res_n,
  pipe_reg_chain_if.slave  pipe,
  input  logic             clr_err,
  input  logic             clr_cnt,
  output logic             err_conflict,
  output logic             err_drop,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        err_conflict_q, err_conflict_d;
  logic                        err_drop_q, err_drop_d;
  logic [CNT_W-1:0]            bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  // Value each stage would take when advancing: its predecessor, or the input for stage 0
  logic [DEPTH-1:0][WIDTH-1:0] src_data;
  logic [DEPTH-1:0]            src_valid;
  // Per-stage "a valid entry is about to be overwritten while its successor holds"
  logic [DEPTH-1:0]            drop_vec;

  if (DEPTH > 1) begin : g_chain
    assign src_data  = {data_q[DEPTH-2:0], pipe.in_data};
    assign src_valid = {valid_q[DEPTH-2:0], pipe.in_valid};
    assign drop_vec  = {pipe.stall[DEPTH-1:1] & ~pipe.stall[DEPTH-2:0]
                        & valid_q[DEPTH-2:0] & ~pipe.bubble[DEPTH-2:0],
                        pipe.stall[0] & pipe.in_valid};
  end else begin : g_single
    assign src_data  = pipe.in_data;
    assign src_valid = pipe.in_valid;
    assign drop_vec  = pipe.stall[0] & pipe.in_valid;
  end

  // Stage next-state: stall holds, otherwise bubble squashes, otherwise advance
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe.stall[i]) begin
        data_d[i]  = data_q[i];
        valid_d[i] = valid_q[i];
      end else if (pipe.bubble[i]) begin
        data_d[i]  = BUBBLE_VAL;
        valid_d[i] = 1'b0;
      end else begin
        data_d[i]  = src_data[i];
        valid_d[i] = src_valid[i];
      end
    end
  end

  // Sticky error flags: a new event in the clearing cycle keeps the flag set
  always_comb begin
    err_conflict_d = err_conflict_q;
    err_drop_d     = err_drop_q;
    if (clr_err) begin
      err_conflict_d = 1'b0;
      err_drop_d     = 1'b0;
    end
    if (|(pipe.stall & pipe.bubble)) err_conflict_d = 1'b1;
    if (|drop_vec)                   err_drop_d     = 1'b1;
  end

  // Saturating perf counters on pre-edge state; clear beats a coincident increment
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (clr_cnt) begin
      bubble_cnt_d = '0;
      stall_cnt_d  = '0;
    end else begin
      if (!valid_q[DEPTH-1] && bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      if ((|pipe.stall) && stall_cnt_q != CNT_MAX)      stall_cnt_d  = stall_cnt_q + CNT_ONE;
    end
  end

  // State registers; reset empties the pipe and clears all status
  always_ff @(posedge clk) begin
    if (!res_n) begin
      data_q         <= {DEPTH{BUBBLE_VAL}};
      valid_q        <= '0;
      err_conflict_q <= 1'b0;
      err_drop_q     <= 1'b0;
      bubble_cnt_q   <= '0;
      stall_cnt_q    <= '0;
    end else begin
      data_q         <= data_d;
      valid_q        <= valid_d;
      err_conflict_q <= err_conflict_d;
      err_drop_q     <= err_drop_d;
      bubble_cnt_q   <= bubble_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign pipe.out_data  = data_q;
  assign pipe.out_valid = valid_q;
  assign err_conflict   = err_conflict_q;
  assign err_drop       = err_drop_q;
  assign bubble_cnt     = bubble_cnt_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - scoreboard bench for pipe_reg_chain with directed vectors
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       res_n;
  logic       clr_err;
  logic       clr_cnt;
  logic       err_conflict;
  logic       err_drop;
  logic [3:0] bubble_cnt;
  logic [3:0] stall_cnt;

  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(3)) pif ();

  pipe_reg_chain #(
    .WIDTH(8), .DEPTH(3), .BUBBLE_VAL(8'hB0), .CNT_W(4)
  ) dut (
    .clk          (clk),
    .res_n        (res_n),
    .pipe         (pif),
    .clr_err      (clr_err),
    .clr_cnt      (clr_cnt),
    .err_conflict (err_conflict),
    .err_drop     (err_drop),
    .bubble_cnt   (bubble_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [23:0] data;
    logic [2:0] valid;
    logic       conf;
    logic       drop;
    logic [3:0] bcnt;
    logic [3:0] scnt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the expectation tagged for this edge
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      check("missed_expectation", sb_q[0].cyc, 32'(cyc), 32'(sb_q[0].cyc));
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      check("out_data",     e.cyc, 32'(pif.out_data),  32'(e.data));
      check("out_valid",    e.cyc, 32'(pif.out_valid), 32'(e.valid));
      check("err_conflict", e.cyc, 32'(err_conflict),  32'(e.conf));
      check("err_drop",     e.cyc, 32'(err_drop),      32'(e.drop));
      check("bubble_cnt",   e.cyc, 32'(bubble_cnt),    32'(e.bcnt));
      check("stall_cnt",    e.cyc, 32'(stall_cnt),     32'(e.scnt));
    end
  end

  // Driver: apply inputs for the coming edge and queue what that edge must produce
  task automatic step(input logic rn, input logic [7:0] d, input logic v,
                      input logic [2:0] st, input logic [2:0] bu,
                      input logic ce, input logic cc,
                      input logic [23:0] ed, input logic [2:0] ev,
                      input logic ec, input logic edr,
                      input logic [3:0] eb, input logic [3:0] es);
    exp_t e;
    res_n        = rn;
    pif.in_data  = d;
    pif.in_valid = v;
    pif.stall    = st;
    pif.bubble   = bu;
    clr_err      = ce;
    clr_cnt      = cc;
    e.cyc = cyc + 1; e.data = ed; e.valid = ev; e.conf = ec; e.drop = edr; e.bcnt = eb; e.scnt = es;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0; pif.in_data = '0; pif.in_valid = 1'b0;
    pif.stall = '0; pif.bubble = '0; clr_err = 1'b0; clr_cnt = 1'b0;

    //    rn  din    v  stall   bubble  ce cc  exp_data      ev      cf dr  bc     sc
    // Reset for two edges, then flow
    step(0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 24'hB0B0B0, 3'b000, 0, 0, 4'd0, 4'd0);
    step(0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 24'hB0B0B0, 3'b000, 0, 0, 4'd0, 4'd0);
    step(1, 8'h11, 1, 3'b000, 3'b000, 0, 0, 24'hB0B011, 3'b001, 0, 0, 4'd1, 4'd0);
    step(1, 8'h22, 1, 3'b000, 3'b000, 0, 0, 24'hB01122, 3'b011, 0, 0, 4'd2, 4'd0);
    step(1, 8'h33, 1, 3'b000, 3'b000, 0, 0, 24'h112233, 3'b111, 0, 0, 4'd3, 4'd0);
    step(1, 8'h44, 1, 3'b000, 3'b000, 0, 0, 24'h223344, 3'b111, 0, 0, 4'd3, 4'd0);
    step(1, 8'h55, 1, 3'b000, 3'b000, 0, 0, 24'h334455, 3'b111, 0, 0, 4'd3, 4'd0);
    // Reset and refill 33/22/11
    step(0, 8'h00, 0, 3'b000, 3'b000, 0, 0, 24'hB0B0B0, 3'b000, 0, 0, 4'd0, 4'd0);
    step(1, 8'h11, 1, 3'b000, 3'b000, 0, 0, 24'hB0B011, 3'b001, 0, 0, 4'd1, 4'd0);
    step(1, 8'h22, 1, 3'b000, 3'b000, 0, 0, 24'hB01122, 3'b011, 0, 0, 4'd2, 4'd0);
    step(1, 8'h33, 1, 3'b000, 3'b000, 0, 0, 24'h112233, 3'b111, 0, 0, 4'd3, 4'd0);
    // Load/use stall
    step(1, 8'h44, 0, 3'b011, 3'b100, 0, 0, 24'hB02233, 3'b011, 0, 0, 4'd3, 4'd1);
    // Mispredict squash
    step(1, 8'h55, 1, 3'b000, 3'b011, 0, 0, 24'h22B0B0, 3'b100, 0, 0, 4'd4, 4'd1);
    // Conflict on stage 1, then drop at stage 0 -> 1, then clear
    step(1, 8'h66, 1, 3'b010, 3'b010, 0, 0, 24'hB0B066, 3'b001, 1, 0, 4'd4, 4'd2);
    step(1, 8'h77, 1, 3'b010, 3'b000, 0, 0, 24'hB0B077, 3'b001, 1, 1, 4'd5, 4'd3);
    step(1, 8'h00, 0, 3'b000, 3'b000, 1, 0, 24'hB07700, 3'b010, 0, 0, 4'd6, 4'd3);
    // Stage-0 drop: in_data not captured
    step(1, 8'h88, 1, 3'b001, 3'b000, 0, 0, 24'h770000, 3'b100, 0, 1, 4'd7, 4'd4);
    // Drop coinciding with clr_err: set wins
    step(1, 8'h99, 1, 3'b001, 3'b000, 1, 0, 24'h000000, 3'b000, 0, 1, 4'd7, 4'd5);
    step(1, 8'h00, 0, 3'b000, 3'b000, 1, 0, 24'h000000, 3'b000, 0, 0, 4'd8, 4'd5);
    // Idle run: bubble_cnt saturates at F
    for (int k = 1; k <= 20; k++) begin
      step(1, 8'h00, 0, 3'b000, 3'b000, 0, 0, 24'h000000, 3'b000, 0, 0,
           (8 + k > 15) ? 4'hF : 4'(8 + k), 4'd5);
    end
    // clr_cnt with a coincident increment yields 0
    step(1, 8'h00, 0, 3'b000, 3'b000, 0, 1, 24'h000000, 3'b000, 0, 0, 4'd0, 4'd0);
    // Mid-stream reset overriding stall/bubble conflict
    step(1, 8'hAA, 1, 3'b000, 3'b000, 0, 0, 24'h0000AA, 3'b001, 0, 0, 4'd1, 4'd0);
    step(1, 8'hBB, 1, 3'b000, 3'b000, 0, 0, 24'h00AABB, 3'b011, 0, 0, 4'd2, 4'd0);
    step(0, 8'hCC, 1, 3'b011, 3'b011, 0, 0, 24'hB0B0B0, 3'b000, 0, 0, 4'd0, 4'd0);
    step(1, 8'hDD, 1, 3'b000, 3'b000, 0, 0, 24'hB0B0DD, 3'b001, 0, 0, 4'd1, 4'd0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", cyc, 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
